// File: rtl/lsu_dccm_arb.sv
// DCCM command arbiter: LSU pipe, DMA slave and store-buffer drain share
// one single-ported DCCM; aging counters keep DMA and drain from starving.
module lsu_dccm_arb #(
   parameter int DCCM_BITS        = 16,
   parameter int DCCM_FDATA_WIDTH = 39,
   parameter int DMA_MAX_WAIT     = 4,
   parameter int SB_MAX_WAIT      = 8
) (
   input  logic                        clk,
   input  logic                        rst_l,
   input  logic                        lsu_freeze_dc3,
   input  logic                        lsu_req,
   input  logic                        lsu_wr,
   input  logic [DCCM_BITS-1:0]        lsu_addr_lo,
   input  logic [DCCM_BITS-1:0]        lsu_addr_hi,
   input  logic [DCCM_FDATA_WIDTH-1:0] lsu_wr_data,
   output logic                        lsu_stall,
   output logic                        lsu_rd_valid,
   input  logic                        dma_req,
   input  logic                        dma_wr,
   input  logic [DCCM_BITS-1:0]        dma_addr,
   input  logic [DCCM_FDATA_WIDTH-1:0] dma_wr_data,
   output logic                        dma_gnt,
   output logic                        dma_rd_valid,
   input  logic                        sb_req,
   input  logic [DCCM_BITS-1:0]        sb_addr,
   input  logic [DCCM_FDATA_WIDTH-1:0] sb_wr_data,
   output logic                        sb_gnt,
   output logic                        dccm_wren,
   output logic                        dccm_rden,
   output logic [DCCM_BITS-1:0]        dccm_wr_addr,
   output logic [DCCM_BITS-1:0]        dccm_rd_addr_lo,
   output logic [DCCM_BITS-1:0]        dccm_rd_addr_hi,
   output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data
);

   localparam int DAW = $clog2(DMA_MAX_WAIT + 1);
   localparam int SAW = $clog2(SB_MAX_WAIT + 1);

   logic [DAW-1:0] dma_age_q;
   logic [SAW-1:0] sb_age_q;
   logic           rd_lsu_q;
   logic           rd_dma_q;
   logic           dma_aged;
   logic           sb_aged;
   logic           lsu_win;
   logic           dma_win;
   logic           sb_win;
   logic           frz;

   assign frz      = lsu_freeze_dc3;
   assign dma_aged = (dma_age_q == DAW'(DMA_MAX_WAIT));
   assign sb_aged  = (sb_age_q == SAW'(SB_MAX_WAIT));

   // Aged requesters jump the LSU; DMA wins when both are aged.
   always_comb begin
      lsu_win = 1'b0;
      dma_win = 1'b0;
      sb_win  = 1'b0;
      if (!frz) begin
         priority case (1'b1)
            dma_req && dma_aged: dma_win = 1'b1;
            sb_req && sb_aged:   sb_win  = 1'b1;
            lsu_req:             lsu_win = 1'b1;
            dma_req:             dma_win = 1'b1;
            sb_req:              sb_win  = 1'b1;
            default: ;
         endcase
      end
   end

   assign lsu_stall = lsu_req & ~lsu_win;
   assign dma_gnt   = dma_win;
   assign sb_gnt    = sb_win;

   always_comb begin
      dccm_wren       = 1'b0;
      dccm_rden       = 1'b0;
      dccm_wr_addr    = '0;
      dccm_wr_data    = '0;
      dccm_rd_addr_lo = '0;
      dccm_rd_addr_hi = '0;
      unique case (1'b1)
         lsu_win: begin
            if (lsu_wr) begin
               dccm_wren    = 1'b1;
               dccm_wr_addr = lsu_addr_lo;
               dccm_wr_data = lsu_wr_data;
            end else begin
               dccm_rden       = 1'b1;
               dccm_rd_addr_lo = lsu_addr_lo;
               dccm_rd_addr_hi = lsu_addr_hi;
            end
         end
         dma_win: begin
            if (dma_wr) begin
               dccm_wren    = 1'b1;
               dccm_wr_addr = dma_addr;
               dccm_wr_data = dma_wr_data;
            end else begin
               dccm_rden       = 1'b1;
               dccm_rd_addr_lo = dma_addr;
               dccm_rd_addr_hi = dma_addr;
            end
         end
         sb_win: begin
            dccm_wren    = 1'b1;
            dccm_wr_addr = sb_addr;
            dccm_wr_data = sb_wr_data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         dma_age_q <= '0;
         sb_age_q  <= '0;
         rd_lsu_q  <= 1'b0;
         rd_dma_q  <= 1'b0;
      end else if (!frz) begin
         rd_lsu_q <= lsu_win & ~lsu_wr;
         rd_dma_q <= dma_win & ~dma_wr;
         if (dma_req && !dma_win) begin
            if (!dma_aged) dma_age_q <= dma_age_q + 1'b1;
         end else begin
            dma_age_q <= '0;
         end
         if (sb_req && !sb_win) begin
            if (!sb_aged) sb_age_q <= sb_age_q + 1'b1;
         end else begin
            sb_age_q <= '0;
         end
      end
   end

   assign lsu_rd_valid = rd_lsu_q & ~frz;
   assign dma_rd_valid = rd_dma_q & ~frz;

endmodule

// File: tb/tb_lsu_dccm_arb.sv
// Directed bench for lsu_dccm_arb: grants, aging, freeze, reset.
module tb_lsu_dccm_arb;

   logic        clk = 1'b0;
   logic        rst_l;
   logic        frz;
   logic        lsu_req, lsu_wr;
   logic [15:0] lsu_addr_lo, lsu_addr_hi;
   logic [38:0] lsu_wr_data;
   logic        lsu_stall, lsu_rd_valid;
   logic        dma_req, dma_wr;
   logic [15:0] dma_addr;
   logic [38:0] dma_wr_data;
   logic        dma_gnt, dma_rd_valid;
   logic        sb_req;
   logic [15:0] sb_addr;
   logic [38:0] sb_wr_data;
   logic        sb_gnt;
   logic        dccm_wren, dccm_rden;
   logic [15:0] dccm_wr_addr, dccm_rd_addr_lo, dccm_rd_addr_hi;
   logic [38:0] dccm_wr_data;
   logic [4:0]  stat;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   assign stat = {lsu_stall, dma_gnt, sb_gnt, dccm_wren, dccm_rden};

   lsu_dccm_arb dut (
      .clk(clk), .rst_l(rst_l), .lsu_freeze_dc3(frz),
      .lsu_req(lsu_req), .lsu_wr(lsu_wr),
      .lsu_addr_lo(lsu_addr_lo), .lsu_addr_hi(lsu_addr_hi),
      .lsu_wr_data(lsu_wr_data), .lsu_stall(lsu_stall),
      .lsu_rd_valid(lsu_rd_valid),
      .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr),
      .dma_wr_data(dma_wr_data), .dma_gnt(dma_gnt),
      .dma_rd_valid(dma_rd_valid),
      .sb_req(sb_req), .sb_addr(sb_addr), .sb_wr_data(sb_wr_data),
      .sb_gnt(sb_gnt),
      .dccm_wren(dccm_wren), .dccm_rden(dccm_rden),
      .dccm_wr_addr(dccm_wr_addr), .dccm_rd_addr_lo(dccm_rd_addr_lo),
      .dccm_rd_addr_hi(dccm_rd_addr_hi), .dccm_wr_data(dccm_wr_data)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      frz = 0;
      lsu_req = 0; lsu_wr = 0; lsu_addr_lo = '0; lsu_addr_hi = '0;
      lsu_wr_data = '0;
      dma_req = 0; dma_wr = 0; dma_addr = '0; dma_wr_data = '0;
      sb_req = 0; sb_addr = '0; sb_wr_data = '0;
   endtask

   task automatic test_reset();
      idle();
      rst_l = 0;
      #12;
      n_cmp++;
      if (stat !== 5'b0 || lsu_rd_valid !== 1'b0 || dma_rd_valid !== 1'b0) begin
         $display("FAIL reset_ctrl stat=%b lrv=%b drv=%b want 0", stat, lsu_rd_valid, dma_rd_valid);
         n_err++;
      end
      n_cmp++;
      if ({dccm_wr_addr, dccm_rd_addr_lo, dccm_rd_addr_hi, dccm_wr_data} !== '0) begin
         $display("FAIL reset_bus wa=%h lo=%h hi=%h wd=%h want 0",
                  dccm_wr_addr, dccm_rd_addr_lo, dccm_rd_addr_hi, dccm_wr_data);
         n_err++;
      end
      tick();
      rst_l = 1;
      tick();
   endtask

   task automatic test_lsu_read();
      lsu_req = 1; lsu_addr_lo = 16'h0010; lsu_addr_hi = 16'h0014;
      #2;
      n_cmp++;
      if (stat !== 5'b00001 || dccm_rd_addr_lo !== 16'h0010 || dccm_rd_addr_hi !== 16'h0014) begin
         $display("FAIL lsu_rd_cmd stat=%b lo=%h hi=%h want 00001/0010/0014",
                  stat, dccm_rd_addr_lo, dccm_rd_addr_hi);
         n_err++;
      end
      n_cmp++;
      if (lsu_rd_valid !== 1'b0) begin
         $display("FAIL lsu_rd_early got=%b want 0", lsu_rd_valid);
         n_err++;
      end
      tick();
      idle();
      #2;
      n_cmp++;
      if (lsu_rd_valid !== 1'b1 || dma_rd_valid !== 1'b0 || stat !== 5'b0) begin
         $display("FAIL lsu_rd_valid lrv=%b drv=%b stat=%b want 1/0/0",
                  lsu_rd_valid, dma_rd_valid, stat);
         n_err++;
      end
      tick();
      n_cmp++;
      if (lsu_rd_valid !== 1'b0) begin
         $display("FAIL lsu_rd_once got=%b want 0", lsu_rd_valid);
         n_err++;
      end
      tick();
   endtask

   task automatic test_dma_aging();
      lsu_req = 1; lsu_addr_lo = 16'h0020; lsu_addr_hi = 16'h0020;
      dma_req = 1; dma_addr = 16'h0040;
      for (int c = 1; c <= 10; c++) begin
         #2;
         n_cmp++;
         if (dma_gnt !== (c == 5 || c == 10) || lsu_stall !== (c == 5 || c == 10)) begin
            $display("FAIL dma_age c=%0d gnt=%b stall=%b want %b", c, dma_gnt, lsu_stall,
                     (c == 5 || c == 10));
            n_err++;
         end
         n_cmp++;
         if (dma_rd_valid !== (c == 6) || lsu_rd_valid !== (c >= 2 && c != 6)) begin
            $display("FAIL dma_age_rv c=%0d drv=%b lrv=%b", c, dma_rd_valid, lsu_rd_valid);
            n_err++;
         end
         if (c == 5) begin
            n_cmp++;
            if (dccm_rd_addr_lo !== 16'h0040 || dccm_rd_addr_hi !== 16'h0040) begin
               $display("FAIL dma_rd_addr lo=%h hi=%h want 0040", dccm_rd_addr_lo, dccm_rd_addr_hi);
               n_err++;
            end
         end
         tick();
      end
      idle();
      tick();
   endtask

   task automatic test_freeze();
      dma_req = 1; dma_addr = 16'h0080;
      #2;
      n_cmp++;
      if (stat !== 5'b01001) begin
         $display("FAIL frz_grant stat=%b want 01001", stat);
         n_err++;
      end
      tick();
      dma_req = 0; frz = 1; lsu_req = 1; sb_req = 1; sb_addr = 16'h0200;
      for (int c = 0; c < 3; c++) begin
         #2;
         n_cmp++;
         if (stat !== 5'b10000 || dma_rd_valid !== 1'b0) begin
            $display("FAIL frz_hold c=%0d stat=%b drv=%b want 10000/0", c, stat, dma_rd_valid);
            n_err++;
         end
         tick();
      end
      idle();
      #2;
      n_cmp++;
      if (dma_rd_valid !== 1'b1) begin
         $display("FAIL frz_release drv=%b want 1", dma_rd_valid);
         n_err++;
      end
      tick();
      n_cmp++;
      if (dma_rd_valid !== 1'b0) begin
         $display("FAIL frz_once drv=%b want 0", dma_rd_valid);
         n_err++;
      end
      tick();
   endtask

   task automatic test_all_three();
      int exp_w [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 2, 1, 0, 0};
      logic [4:0] want;
      lsu_req = 1; lsu_addr_lo = 16'h0030; lsu_addr_hi = 16'h0034;
      dma_req = 1; dma_wr = 1; dma_addr = 16'h0050; dma_wr_data = 39'h55;
      sb_req = 1; sb_addr = 16'h0060; sb_wr_data = 39'h66;
      for (int c = 0; c < 12; c++) begin
         want = (exp_w[c] == 0) ? 5'b00001 : (exp_w[c] == 1) ? 5'b11010 : 5'b10110;
         #2;
         n_cmp++;
         if (stat !== want) begin
            $display("FAIL all3 c=%0d stat=%b want %b", c + 1, stat, want);
            n_err++;
         end
         if (exp_w[c] == 2) begin
            n_cmp++;
            if (dccm_wr_addr !== 16'h0060 || dccm_wr_data !== 39'h66) begin
               $display("FAIL all3_sb wa=%h wd=%h want 0060/66", dccm_wr_addr, dccm_wr_data);
               n_err++;
            end
         end
         tick();
      end
      idle();
      tick();
   endtask

   task automatic test_both_aged();
      int exp_w [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0};
      logic [4:0] want;
      lsu_req = 1; lsu_wr = 1; lsu_addr_lo = 16'h0070;
      sb_req = 1; sb_addr = 16'h0090;
      for (int c = 0; c < 12; c++) begin
         if (c == 4) begin
            dma_req = 1; dma_wr = 1; dma_addr = 16'h00A0;
         end
         want = (exp_w[c] == 0) ? ((c >= 4) ? 5'b00010 : 5'b00010)
              : (exp_w[c] == 1) ? 5'b11010 : 5'b10110;
         #2;
         n_cmp++;
         if (stat !== want) begin
            $display("FAIL both_aged c=%0d stat=%b want %b", c + 1, stat, want);
            n_err++;
         end
         if (exp_w[c] == 0) begin
            n_cmp++;
            if (dccm_wr_addr !== 16'h0070) begin
               $display("FAIL both_aged_lsu c=%0d wa=%h want 0070", c + 1, dccm_wr_addr);
               n_err++;
            end
         end
         tick();
      end
      idle();
      tick();
   endtask

   task automatic test_sb_write();
      sb_req = 1; sb_addr = 16'h0100; sb_wr_data = 39'h12345678;
      #2;
      n_cmp++;
      if (stat !== 5'b00110 || dccm_wr_addr !== 16'h0100 || dccm_wr_data !== 39'h12345678) begin
         $display("FAIL sb_write stat=%b wa=%h wd=%h want 00110/0100/12345678",
                  stat, dccm_wr_addr, dccm_wr_data);
         n_err++;
      end
      n_cmp++;
      if (dccm_rd_addr_lo !== 16'h0 || dccm_rd_addr_hi !== 16'h0) begin
         $display("FAIL sb_rd_idle lo=%h hi=%h want 0", dccm_rd_addr_lo, dccm_rd_addr_hi);
         n_err++;
      end
      tick();
      idle();
      tick();
   endtask

   task automatic test_reset_mid_read();
      lsu_req = 1; lsu_wr = 1; lsu_addr_lo = 16'h00B0;
      sb_req = 1; sb_addr = 16'h00C0;
      repeat (3) tick();
      lsu_req = 0; dma_req = 1; dma_addr = 16'h00D0;
      #2;
      n_cmp++;
      if (dma_gnt !== 1'b1 || sb_gnt !== 1'b0) begin
         $display("FAIL rst_pre_gnt dg=%b sg=%b want 1/0", dma_gnt, sb_gnt);
         n_err++;
      end
      tick();
      dma_req = 0; lsu_req = 1;
      n_cmp++;
      if (dma_rd_valid !== 1'b1) begin
         $display("FAIL rst_pre_rv drv=%b want 1", dma_rd_valid);
         n_err++;
      end
      rst_l = 0;
      #1;
      n_cmp++;
      if (dma_rd_valid !== 1'b0) begin
         $display("FAIL rst_drop drv=%b want 0", dma_rd_valid);
         n_err++;
      end
      tick();
      rst_l = 1;
      // SB counter restarts from zero: eight more denials before grant.
      for (int c = 1; c <= 9; c++) begin
         #2;
         n_cmp++;
         if (sb_gnt !== (c == 9) || lsu_stall !== (c == 9)) begin
            $display("FAIL rst_age c=%0d sg=%b stall=%b want %b", c, sb_gnt, lsu_stall, (c == 9));
            n_err++;
         end
         tick();
      end
      idle();
      tick();
   endtask

   initial begin
      rst_l = 1;
      idle();
      #1;
      test_reset();
      test_lsu_read();
      test_dma_aging();
      test_freeze();
      test_all_three();
      test_both_aged();
      test_sb_write();
      test_reset_mid_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
